ar_skid_reg: RTL and testbench
==============================

Name: ar_skid_reg

Overview:
- Parametrised successor to the plain datapath holding register (ALU-result, memory-data and similar registers) in the multi-cycle CPU.
- Adds a clock, a valid/ready handshake on both sides and a 2-entry skid buffer, so a producing stage can keep issuing while the consuming stage stalls.
- Adds a synchronous flush for aborting an instruction mid-flight, and a wrapping transfer counter for debug and performance visibility.

Parameters:
- DATA_WIDTH, 32, width of the held data word
- CNT_WIDTH, 16, width of the output transfer counter

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  producer offers in_data
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_WIDTH  producer data
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  DATA_WIDTH  head word
- count  output  2  number of words held (0..2)
- xfer_cnt  output  CNT_WIDTH  number of words delivered downstream

Behaviour:
- Storage is two registers: head (drives out_data) and skid.
- FSM states: EMPTY (count=0), ONE (count=1), FULL (count=2).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (state != FULL). It is a function of state only and has no combinational path from out_ready.
- out_valid = (state != EMPTY). Exception: bypass, see Optional Feature.
- Transitions when flush=0:
  - EMPTY: push -> ONE, head <= in_data.
  - ONE: push & pop -> ONE, head <= in_data.
  - ONE: push only -> FULL, skid <= in_data.
  - ONE: pop only -> EMPTY.
  - FULL: pop -> ONE, head <= skid.
  - No push is possible in FULL.
- Latency: 1 cycle minimum from input acceptance to out_valid. Order is strict FIFO and no word is duplicated or dropped.
- Throughput: 1 word/cycle sustained whenever out_ready stays high.
- flush=1 (highest priority after rst):
  - Next state is EMPTY.
  - A word pushed in the same cycle is discarded.
  - A pop in the same cycle still counts as delivered: the consumer saw it, so xfer_cnt increments.
  - head and skid keep their values.
- Reset (rst=1 at a clock edge), applies at any point including mid-transfer:
  - state <= EMPTY; head, skid <= 0; xfer_cnt <= 0.
  - Resulting outputs: out_valid=0, in_ready=1, count=0, out_data=0.
  - rst overrides flush and any handshake in the same cycle.
- When out_valid=0, out_data shows the stale head value. Consumers must ignore it.
- xfer_cnt increments by 1 on every pop and wraps from 2^CNT_WIDTH-1 to 0. flush does not clear it.
- count is registered and reflects state.

Optional Feature:
- Macro: AR_SKID_BYPASS_EN.
- When defined, and state=EMPTY with in_valid=1, out_ready=1 and flush=0:
  - out_valid=1 and out_data=in_data in the same cycle (zero-latency pass-through).
  - The word is consumed immediately: state stays EMPTY and xfer_cnt increments.
  - All other cases behave exactly as without the macro.
- When undefined: no combinational in->out path; minimum latency is 1 cycle.

Test Plan:
- Reset then stream: rst high 2 cycles, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after first push (0 cycles with AR_SKID_BYPASS_EN); xfer_cnt=3; count never exceeds 1.
- Backpressure fill: out_ready=0, push 0xA0,0xA1 -> count=2, in_ready=0, in_valid held with 0xA2 not accepted; raise out_ready -> outputs 0xA0,0xA1,0xA2 in order; in_ready returns 1 in the cycle after the first pop.
- Flush mid-flight: FULL with 0xB0,0xB1, flush=1 with in_valid=1 data 0xB2, out_ready=0 -> next cycle count=0, out_valid=0, 0xB2 never appears; xfer_cnt unchanged.
- Flush with simultaneous pop: state ONE holding 0xC0, flush=1, out_ready=1 -> xfer_cnt +1, next cycle EMPTY.
- Counter wrap: CNT_WIDTH=4, deliver 17 words -> xfer_cnt=1 after the 17th pop.
- Reset mid-operation: FULL, assert rst with in_valid=1, out_ready=1 -> next cycle out_valid=0, out_data=0, count=0, xfer_cnt=0, in_ready=1.

Source files
------------

// File: rtl/ar_skid_reg.sv
// Valid/ready holding register with a 2-entry skid buffer, synchronous flush and a wrapping transfer counter.
// Define AR_SKID_BYPASS_EN for zero-latency pass-through when the buffer is empty.
module ar_skid_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  // State encoding equals the number of held words, so count is the state register itself.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [CNT_WIDTH-1:0]  xfer_q, xfer_d;
  logic                  push_s;
  logic                  pop_s;
  logic                  bypass_s;

  // Handshake outputs, optional pass-through and next-state selection.
  always_comb begin
    bypass_s = 1'b0;
`ifdef AR_SKID_BYPASS_EN
    bypass_s = (state_q == ST_EMPTY) & in_valid & out_ready & ~flush;
`else
    bypass_s = 1'b0;
`endif
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY) | bypass_s;
    out_data  = bypass_s ? in_data : head_q;
    // A bypassed word is consumed on the spot and never enters storage.
    push_s    = in_valid & in_ready & ~bypass_s;
    pop_s     = out_valid & out_ready;

    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    xfer_d  = pop_s ? (xfer_q + CNT_ONE) : xfer_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d = ST_ONE;
            head_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            state_d = ST_ONE;
            head_d  = in_data;
          end else if (push_s) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State, storage and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= {DATA_WIDTH{1'b0}};
      skid_q  <= {DATA_WIDTH{1'b0}};
      xfer_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      xfer_q  <= xfer_d;
    end
  end

  assign count    = state_q;
  assign xfer_cnt = xfer_q;

endmodule

// File: tb/tb_ar_skid_reg.sv
// Directed self-checking bench for ar_skid_reg (default build, CNT_WIDTH=4 to exercise counter wrap).
module tb_ar_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;
  logic [3:0]  xfer_cnt;

  int checks_r;
  int errors_r;

  ar_skid_reg #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .xfer_cnt (xfer_cnt)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios; inputs change 1 time unit after each rising edge.
  initial begin
    checks_r  = 0;
    errors_r  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_count", {30'd0, count}, 32'd0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_xfer", {28'd0, xfer_cnt}, 32'd0);

    // Stream with out_ready high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    check_eq("st_valid1", {31'd0, out_valid}, 32'd1);
    check_eq("st_data1", out_data, 32'h11);
    check_eq("st_count1", {30'd0, count}, 32'd1);
    in_data = 32'h22;
    tick();
    check_eq("st_data2", out_data, 32'h22);
    check_eq("st_count2", {30'd0, count}, 32'd1);
    in_data = 32'h33;
    tick();
    check_eq("st_data3", out_data, 32'h33);
    check_eq("st_xfer2", {28'd0, xfer_cnt}, 32'd2);
    in_valid = 1'b0;
    tick();
    check_eq("st_xfer3", {28'd0, xfer_cnt}, 32'd3);
    check_eq("st_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure fill.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA0;
    tick();
    in_data = 32'hA1;
    tick();
    check_eq("bp_count_full", {30'd0, count}, 32'd2);
    check_eq("bp_in_ready0", {31'd0, in_ready}, 32'd0);
    in_data = 32'hA2;
    tick();
    check_eq("bp_hold_count", {30'd0, count}, 32'd2);
    check_eq("bp_hold_head", out_data, 32'hA0);
    out_ready = 1'b1;
    tick();
    check_eq("bp_data_a1", out_data, 32'hA1);
    check_eq("bp_in_ready1", {31'd0, in_ready}, 32'd1);
    check_eq("bp_count1", {30'd0, count}, 32'd1);
    tick();
    check_eq("bp_data_a2", out_data, 32'hA2);
    check_eq("bp_xfer5", {28'd0, xfer_cnt}, 32'd5);
    in_valid = 1'b0;
    tick();
    check_eq("bp_xfer6", {28'd0, xfer_cnt}, 32'd6);
    check_eq("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush while full, with a word offered in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB0;
    tick();
    in_data = 32'hB1;
    tick();
    check_eq("fl_full", {30'd0, count}, 32'd2);
    flush   = 1'b1;
    in_data = 32'hB2;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_count", {30'd0, count}, 32'd0);
    check_eq("fl_valid", {31'd0, out_valid}, 32'd0);
    check_eq("fl_xfer", {28'd0, xfer_cnt}, 32'd6);
    out_ready = 1'b1;
    tick();
    check_eq("fl_no_b2", {31'd0, out_valid}, 32'd0);
    check_eq("fl_xfer_still", {28'd0, xfer_cnt}, 32'd6);

    // Flush with a simultaneous pop still counts the delivery.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hC0;
    tick();
    in_valid  = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fp_xfer7", {28'd0, xfer_cnt}, 32'd7);
    check_eq("fp_count", {30'd0, count}, 32'd0);
    check_eq("fp_stale_head", out_data, 32'hC0);

    // Reset in the middle of a full buffer with active handshakes.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD0;
    tick();
    in_data = 32'hD1;
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_eq("mr_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mr_data", out_data, 32'h0);
    check_eq("mr_count", {30'd0, count}, 32'd0);
    check_eq("mr_xfer", {28'd0, xfer_cnt}, 32'd0);
    check_eq("mr_in_ready", {31'd0, in_ready}, 32'd1);

    // Deliver 17 words through a 4-bit counter.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 32'h100 + i;
      tick();
      check_eq("wr_order", out_data, 32'h100 + i);
    end
    check_eq("wr_xfer16", {28'd0, xfer_cnt}, 32'd0);
    in_valid = 1'b0;
    tick();
    check_eq("wr_xfer17", {28'd0, xfer_cnt}, 32'd1);
    check_eq("wr_count", {30'd0, count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
